// File: rtl/simplez_pkg.sv
// simplez_pkg: shared opcode, ALU and FSM state definitions for the Simplez CPU.
// The optional WAIT instruction is controlled by the SIMPLEZ_WAIT_EN macro.
package simplez_pkg;

    typedef enum logic [2:0] {
        OP_ST  = 3'd0,
        OP_LD  = 3'd1,
        OP_ADD = 3'd2,
        OP_BR  = 3'd3,
        OP_BZ  = 3'd4,
        OP_CLR = 3'd5,
        OP_DEC = 3'd6,
        OP_EXT = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_CLR,
        ALU_ADD,
        ALU_DEC
    } aluop_e;

`ifdef SIMPLEZ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        TIMER,
        STOP
    } state_e;
`else
    localparam bit WAIT_EN = 1'b0;
    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        STOP
    } state_e;
`endif

    // EXT sub-opcode: the top CD bit selects WAIT (1) or HALT (0).
    // Without the WAIT feature every EXT is a HALT.
    function automatic logic extIsWait(input logic subBit);
        return subBit & WAIT_EN;
    endfunction

endpackage

// File: rtl/simplez_if.sv
// simplez_if: single-master req/ack memory bus used for both fetches and data accesses.
interface simplez_if #(
    parameter int DW = 12,
    parameter int AW = 9
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/simplez_alu.sv
// simplez_alu: combinational accumulator datapath (pass operand, clear, add, decrement)
// with a zero flag on the truncated result.
module simplez_alu
    import simplez_pkg::*;
#(
    parameter int DW = 12
) (
    input  aluop_e        op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o
);

    // Select the new accumulator value; arithmetic wraps modulo 2^DW.
    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_PASS: result_o = b_i;
            ALU_CLR:  result_o = '0;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_DEC:  result_o = a_i - DW'(1);
            default:  result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/simplez_cpu.sv
// simplez_cpu: multi-cycle Simplez accumulator CPU driving one req/ack memory bus.
// Defining SIMPLEZ_WAIT_EN adds the WAIT instruction (TIMER state and cycle counter);
// without it an EXT instruction always halts.
module simplez_cpu
    import simplez_pkg::*;
#(
    parameter int DW          = 12,
    parameter int AW          = 9,
    parameter int WAIT_CYCLES = 2400000
) (
    input  logic          clk,
    input  logic          rstn,
    simplez_if.master     bus,
    output logic          halted,
    output logic [AW-1:0] pc
);

    if (DW < AW + 3) begin : gBadWidth
        $error("simplez_cpu: DW must be at least AW+3");
    end
    if (WAIT_CYCLES < 1) begin : gBadWait
        $error("simplez_cpu: WAIT_CYCLES must be at least 1");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic          z_q, z_d;
    logic          started_q;

`ifdef SIMPLEZ_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          isWait;
    assign isWait = extIsWait(ir_q[AW-1]);
`endif

    opcode_e       op;
    logic [AW-1:0] cd;
    aluop_e        aluOp;
    logic          loadA;
    logic [DW-1:0] aluResult;
    logic          aluZero;

    assign op = opcode_e'(ir_q[DW-1:DW-3]);
    assign cd = ir_q[AW-1:0];

    simplez_alu #(.DW(DW)) uAlu (
        .op_i    (aluOp),
        .a_i     (a_q),
        .b_i     (bus.mem_rdata),
        .result_o(aluResult),
        .zero_o  (aluZero)
    );

    // State and architectural registers; reset abandons any half-done bus phase.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            z_q       <= 1'b0;
            started_q <= 1'b0;
`ifdef SIMPLEZ_WAIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            z_q       <= z_d;
            started_q <= 1'b1;
`ifdef SIMPLEZ_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state logic: fetch, decode/execute, data access, optional timer, stop.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        z_d     = z_q;
        aluOp   = ALU_PASS;
        loadA   = 1'b0;
`ifdef SIMPLEZ_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (started_q && bus.mem_ack) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (op)
                    OP_ST, OP_LD, OP_ADD: state_d = MEM;
                    OP_BR: begin
                        pc_d    = cd;
                        state_d = FETCH;
                    end
                    OP_BZ: begin
                        if (z_q) pc_d = cd;
                        state_d = FETCH;
                    end
                    OP_CLR: begin
                        aluOp   = ALU_CLR;
                        loadA   = 1'b1;
                        state_d = FETCH;
                    end
                    OP_DEC: begin
                        aluOp   = ALU_DEC;
                        loadA   = 1'b1;
                        state_d = FETCH;
                    end
                    OP_EXT: begin
`ifdef SIMPLEZ_WAIT_EN
                        if (isWait) begin
                            cnt_d   = CW'(WAIT_CYCLES - 1);
                            state_d = TIMER;
                        end else begin
                            state_d = STOP;
                        end
`else
                        state_d = STOP;
`endif
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                if (bus.mem_ack) begin
                    if (op == OP_LD) begin
                        aluOp = ALU_PASS;
                        loadA = 1'b1;
                    end else if (op == OP_ADD) begin
                        aluOp = ALU_ADD;
                        loadA = 1'b1;
                    end
                    state_d = FETCH;
                end
            end
`ifdef SIMPLEZ_WAIT_EN
            TIMER: begin
                if (cnt_q == '0) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            STOP: state_d = STOP;
            default: state_d = FETCH;
        endcase
        if (loadA) begin
            a_d = aluResult;
            z_d = aluZero;
        end
    end

    // Bus and debug outputs decoded purely from registers; the first cycle out of
    // reset (started_q low) never requests.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = a_q;
        halted        = (state_q == STOP);
        pc            = pc_q;
        unique case (state_q)
            FETCH: begin
                bus.mem_req  = started_q;
                bus.mem_addr = pc_q;
            end
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = (op == OP_ST);
                bus.mem_addr = cd;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_simplez_cpu.sv
// tb_simplez_cpu: scoreboard bench for simplez_cpu. An ISA-level reference model predicts
// every bus transaction, the run length and the final memory; a slave process answers the
// bus with configurable wait states and a monitor process checks each acknowledged transfer.
// Honours SIMPLEZ_WAIT_EN the same way as the design.
module tb_simplez_cpu;

    localparam int DW        = 12;
    localparam int AW        = 9;
    localparam int WC        = 5;
    localparam int MEMSZ     = 1 << AW;
    localparam int MASK      = (1 << DW) - 1;
    localparam int DATA_BASE = 'h100;
    localparam int C_ST = 0, C_LD = 1, C_ADD = 2, C_BR = 3, C_BZ = 4, C_CLR = 5, C_DEC = 6, C_EXT = 7;
`ifdef SIMPLEZ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct {
        int addr;
        bit we;
        int wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          halted;
    logic [AW-1:0] pc;

    logic [DW-1:0] mem [MEMSZ];
    logic [DW-1:0] modelMem [MEMSZ];
    txn_t          expQ [$];

    int nChecks = 0;
    int nFails = 0;
    bit armed = 1'b0;
    bit blockWrites = 1'b0;
    int waitMode = 0;
    int waitCount = 0;

    simplez_if #(.DW(DW), .AW(AW)) bus ();

    simplez_cpu #(.DW(DW), .AW(AW), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .halted(halted),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc(input int op, input int cd);
        logic [DW-1:0] w;
        w = DW'((op << AW) | (cd & (MEMSZ - 1)));
        return w;
    endfunction

    function automatic int pickWaits(input int mode, input logic we, input logic [AW-1:0] addr);
        if (mode == 0) return 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return (!we && int'(addr) >= DATA_BASE) ? 3 : 0;
    endfunction

    // ISA-level reference: interprets modelMem, queues expected transfers, returns run length.
    task automatic runModel(output int cycles, output int finalPc);
        int p, a, op, cdv, steps;
        bit z, stop;
        logic [DW-1:0] w;
        txn_t t;
        p = 0; a = 0; z = 0; cycles = 1; steps = 0; stop = 0;
        while (!stop && steps < 1000) begin
            steps++;
            w = modelMem[p];
            t.addr = p; t.we = 0; t.wdata = 0;
            expQ.push_back(t);
            p = (p + 1) % MEMSZ;
            op = int'(w) >> AW;
            cdv = int'(w) % MEMSZ;
            case (op)
                C_ST: begin
                    t.addr = cdv; t.we = 1; t.wdata = a;
                    expQ.push_back(t);
                    modelMem[cdv] = DW'(a);
                    cycles += 3;
                end
                C_LD, C_ADD: begin
                    t.addr = cdv; t.we = 0; t.wdata = 0;
                    expQ.push_back(t);
                    a = (op == C_LD) ? int'(modelMem[cdv]) : ((a + int'(modelMem[cdv])) & MASK);
                    z = (a == 0);
                    cycles += 3;
                end
                C_BR: begin p = cdv; cycles += 2; end
                C_BZ: begin if (z) p = cdv; cycles += 2; end
                C_CLR: begin a = 0; z = 1; cycles += 2; end
                C_DEC: begin a = (a - 1) & MASK; z = (a == 0); cycles += 2; end
                default: begin
                    if (WAIT_EN && ((cdv >> (AW - 1)) & 1) == 1) cycles += 2 + WC;
                    else begin cycles += 2; stop = 1; end
                end
            endcase
        end
        finalPc = p;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " mem_req"}, bus.mem_req, 0);
        checkOutput({tag, " mem_we"}, bus.mem_we, 0);
        checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata, 0);
        checkOutput({tag, " pc"}, pc, 0);
        checkOutput({tag, " halted"}, halted, 0);
    endtask

    // Reset, release and run the program in mem until HALT; check timing, pc and memory.
    task automatic applyStimulus(input string tag);
        int expCycles, expPc, cycles, nBad;
        armed = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        expQ.delete();
        for (int i = 0; i < MEMSZ; i++) modelMem[i] = mem[i];
        runModel(expCycles, expPc);
        waitCount = 0;
        rstn = 1'b1;
        armed = 1'b1;
        #1;
        checkOutput({tag, " req in first cycle"}, bus.mem_req, 0);
        cycles = 0;
        while (!halted && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        #2;
        checkOutput({tag, " halted"}, halted, 1);
        checkOutput({tag, " cycles"}, cycles, expCycles + waitCount);
        checkOutput({tag, " final pc"}, pc, expPc);
        checkOutput({tag, " leftover txns"}, expQ.size(), 0);
        nBad = 0;
        for (int i = 0; i < MEMSZ; i++) if (mem[i] !== modelMem[i]) nBad++;
        checkOutput({tag, " memory words differing"}, nBad, 0);
    endtask

    task automatic clearMem();
        for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
    endtask

    // Memory slave: answers requests with the selected wait-state pattern.
    initial begin
        bit slvActive;
        int slvWaits;
        slvActive = 0;
        slvWaits = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = DW'($urandom);
            if (bus.mem_req) begin
                if (!slvActive) begin
                    slvActive = 1;
                    slvWaits = pickWaits(waitMode, bus.mem_we, bus.mem_addr);
                end
                if (slvWaits == 0 && !(blockWrites && bus.mem_we)) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem[bus.mem_addr];
                    slvActive = 0;
                end else begin
                    if (slvWaits > 0) slvWaits--;
                    waitCount++;
                end
            end else begin
                slvActive = 0;
            end
        end
    end

    // Monitor: checks request stability and pops the scoreboard on every acknowledged transfer.
    initial begin
        bit monActive, monUnstable, hasExp;
        int monAddr;
        bit monWe;
        txn_t e;
        monActive = 0; monUnstable = 0; monAddr = 0; monWe = 0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.mem_req) begin
                if (!monActive) begin
                    monActive = 1;
                    monAddr = int'(bus.mem_addr);
                    monWe = bus.mem_we;
                    monUnstable = 0;
                end else if (int'(bus.mem_addr) != monAddr || bus.mem_we != monWe) begin
                    monUnstable = 1;
                end
                if (bus.mem_ack) begin
                    monActive = 0;
                    if (armed) begin
                        checkOutput("request held stable", monUnstable, 0);
                        hasExp = (expQ.size() > 0);
                        checkOutput("transfer was expected", hasExp, 1);
                        if (hasExp) begin
                            e = expQ.pop_front();
                            checkOutput("txn addr", bus.mem_addr, e.addr);
                            checkOutput("txn we", bus.mem_we, e.we);
                            if (e.we) checkOutput("txn wdata", bus.mem_wdata, e.wdata);
                        end
                    end
                end
            end else begin
                monActive = 0;
            end
        end
    end

    initial begin
        int k, op, n;
        bit seen;
        clearMem();
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("power-on");

        // CLR; ADD [5]; ST [6]; HALT
        clearMem();
        mem[0] = enc(C_CLR, 0); mem[1] = enc(C_ADD, 5); mem[2] = enc(C_ST, 6); mem[3] = enc(C_EXT, 0);
        mem[5] = 12'd3;
        waitMode = 0;
        applyStimulus("clr-add-st");
        checkOutput("clr-add-st mem[6]", mem[6], 3);

        // DEC from zero, Z handling, ADD wrap to zero, taken and untaken BZ
        clearMem();
        mem[0] = enc(C_DEC, 0); mem[1] = enc(C_ST, 'h103); mem[2] = enc(C_BZ, 'h3F);
        mem[3] = enc(C_ADD, 'h100); mem[4] = enc(C_BZ, 'h10); mem[5] = enc(C_EXT, 0);
        mem['h10] = enc(C_ST, 'h101); mem['h11] = enc(C_DEC, 0); mem['h12] = enc(C_ST, 'h102);
        mem['h13] = enc(C_EXT, 0); mem['h100] = 12'd1;
        waitMode = 1;
        applyStimulus("dec-add-bz");
        checkOutput("dec-add-bz A after DEC", mem['h103], 'hFFF);
        checkOutput("dec-add-bz A after ADD", mem['h101], 0);
        checkOutput("dec-add-bz pc at 0x10", mem['h102], 'hFFF);

        // Three wait states on every data read
        clearMem();
        mem[0] = enc(C_LD, 'h100); mem[1] = enc(C_ADD, 'h101); mem[2] = enc(C_ST, 'h102);
        mem[3] = enc(C_LD, 'h103); mem[4] = enc(C_ST, 'h104); mem[5] = enc(C_EXT, 0);
        for (int i = 0; i < 4; i++) mem['h100 + i] = DW'($urandom);
        waitMode = 2;
        applyStimulus("ld-waits");

        // Branch to the last address, then wrap to 0
        clearMem();
        mem[0] = enc(C_BZ, 2); mem[1] = enc(C_BR, MEMSZ - 1); mem[MEMSZ - 1] = enc(C_CLR, 0);
        mem[2] = enc(C_EXT, 0);
        waitMode = 0;
        applyStimulus("pc-wrap");

        // WAIT (or HALT when the feature is absent)
        clearMem();
        mem[0] = enc(C_EXT, 1 << (AW - 1)); mem[1] = enc(C_CLR, 0); mem[2] = enc(C_EXT, 0);
        waitMode = 0;
        applyStimulus("wait");

        // Reset in the middle of a stalled store
        clearMem();
        mem[0] = enc(C_LD, 'h100); mem[1] = enc(C_ST, 'h101); mem[2] = enc(C_EXT, 0);
        mem['h100] = 12'h123;
        armed = 1'b0;
        waitMode = 0;
        blockWrites = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            #1;
            seen = bus.mem_req && bus.mem_we;
            n++;
        end
        checkOutput("mid-store reached store", seen, 1);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("mid-store reset");
        blockWrites = 1'b0;
        mem[0] = enc(C_ST, 'h102); mem[1] = enc(C_EXT, 0); mem['h102] = 12'h777;
        applyStimulus("after-reset");
        checkOutput("after-reset A is zero", mem['h102], 0);

        // Random forward-branching programs with random wait states
        waitMode = 1;
        for (int r = 0; r < 8; r++) begin
            clearMem();
            k = 12;
            for (int i = 0; i < k; i++) begin
                op = int'($urandom_range(0, 6));
                if (op <= C_ADD) mem[i] = enc(op, DATA_BASE + int'($urandom_range(0, 15)));
                else if (op == C_BR || op == C_BZ) mem[i] = enc(op, int'($urandom_range(i + 1, k)));
                else mem[i] = enc(op, int'($urandom));
            end
            mem[k] = enc(C_EXT, int'($urandom_range(0, (1 << (AW - 1)) - 1)));
            for (int i = 0; i < 16; i++) mem[DATA_BASE + i] = DW'($urandom);
            applyStimulus($sformatf("random%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
